// File: rtl/rec_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : rec_frame_assembler
//  Description : Hunts a 2-byte header in a UART byte stream, collects a fixed
//                13-byte frame, verifies its additive checksum and presents
//                the frame as a 104-bit word with a held DataEn level.
//  Ports       : Clk, Rst        - clock, asynchronous active-high reset
//                RxEn, RxData    - one received byte per RxEn pulse
//                DataEn          - frame-valid level, EN_HOLD cycles long
//                DataOut         - assembled frame, first byte in [103:96]
//                ChkErr          - 1-cycle pulse, checksum mismatch
//                TimeoutErr      - 1-cycle pulse, inter-byte gap exceeded
//                OvrErr          - 1-cycle pulse, good frame dropped (busy)
//                FrameCnt        - accepted frame counter, wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module rec_frame_assembler #(
    parameter logic [7:0]  HEAD0   = 8'h55,
    parameter logic [7:0]  HEAD1   = 8'hAA,
    parameter logic [19:0] TIMEOUT = 20'd520000,
    parameter logic [7:0]  EN_HOLD = 8'd16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         RxEn,
    input  logic [7:0]   RxData,
    output logic         DataEn,
    output logic [103:0] DataOut,
    output logic         ChkErr,
    output logic         TimeoutErr,
    output logic         OvrErr,
    output logic [15:0]  FrameCnt
);

    typedef enum logic [1:0] {
        HUNT0 = 2'd0,
        HUNT1 = 2'd1,
        BODY  = 2'd2,
        CHECK = 2'd3
    } state_t;

    // Registered state
    state_t         r_state;
    logic [103:0]   r_shift;
    logic [3:0]     r_byte_cnt;
    logic [7:0]     r_sum;
    logic [19:0]    r_gap_cnt;
    logic [7:0]     r_hold_cnt;
    logic           r_data_en;
    logic [103:0]   r_data_out;
    logic [15:0]    r_frame_cnt;
    logic           r_chk_err;
    logic           r_timeout_err;
    logic           r_ovr_err;

    // Next-state values
    state_t         w_state;
    logic [103:0]   w_shift;
    logic [3:0]     w_byte_cnt;
    logic [7:0]     w_sum;
    logic [19:0]    w_gap_cnt;
    logic [7:0]     w_hold_cnt;
    logic           w_data_en;
    logic [103:0]   w_data_out;
    logic [15:0]    w_frame_cnt;
    logic           w_chk_err;
    logic           w_timeout_err;
    logic           w_ovr_err;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state       <= HUNT0;
            r_shift       <= '0;
            r_byte_cnt    <= '0;
            r_sum         <= '0;
            r_gap_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_data_en     <= 1'b0;
            r_data_out    <= '0;
            r_frame_cnt   <= '0;
            r_chk_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_ovr_err     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_shift       <= w_shift;
            r_byte_cnt    <= w_byte_cnt;
            r_sum         <= w_sum;
            r_gap_cnt     <= w_gap_cnt;
            r_hold_cnt    <= w_hold_cnt;
            r_data_en     <= w_data_en;
            r_data_out    <= w_data_out;
            r_frame_cnt   <= w_frame_cnt;
            r_chk_err     <= w_chk_err;
            r_timeout_err <= w_timeout_err;
            r_ovr_err     <= w_ovr_err;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_shift       = r_shift;
        w_byte_cnt    = r_byte_cnt;
        w_sum         = r_sum;
        w_gap_cnt     = r_gap_cnt;
        w_hold_cnt    = r_hold_cnt;
        w_data_en     = r_data_en;
        w_data_out    = r_data_out;
        w_frame_cnt   = r_frame_cnt;
        w_chk_err     = 1'b0;
        w_timeout_err = 1'b0;
        w_ovr_err     = 1'b0;

        // Hold timer: DataEn drops on the cycle the counter would leave 1,
        // which gives exactly EN_HOLD high cycles.
        if (r_data_en) begin
            if (r_hold_cnt == 8'd1) begin
                w_data_en  = 1'b0;
                w_hold_cnt = 8'd0;
            end else begin
                w_hold_cnt = r_hold_cnt - 8'd1;
            end
        end

        case (r_state)
            HUNT0, CHECK: begin
                w_gap_cnt = 20'd0;
                if (r_state == CHECK) begin
                    // The accumulator holds bytes 0..11, the checksum byte
                    // sits in the low byte of the shift register.
                    if (r_sum == r_shift[7:0]) begin
                        if (!r_data_en) begin
                            w_data_out  = r_shift;
                            w_data_en   = 1'b1;
                            w_hold_cnt  = EN_HOLD;
                            w_frame_cnt = r_frame_cnt + 16'd1;
                        end else begin
                            w_ovr_err = 1'b1;
                        end
                    end else begin
                        w_chk_err = 1'b1;
                    end
                    w_state    = HUNT0;
                    w_byte_cnt = 4'd0;
                    w_sum      = 8'd0;
                end
                // A byte arriving during CHECK is hunted exactly as in HUNT0.
                if (RxEn && (RxData == HEAD0)) begin
                    w_shift    = {96'd0, RxData};
                    w_byte_cnt = 4'd1;
                    w_sum      = RxData;
                    w_state    = HUNT1;
                end
            end

            HUNT1: begin
                if (RxEn) begin
                    w_gap_cnt = 20'd0;
                    if (RxData == HEAD1) begin
                        w_shift    = {r_shift[95:0], RxData};
                        w_byte_cnt = 4'd2;
                        w_sum      = r_sum + RxData;
                        w_state    = BODY;
                    end else if (RxData == HEAD0) begin
                        // Repeated first header byte: treat it as a fresh start.
                        w_shift    = {96'd0, RxData};
                        w_byte_cnt = 4'd1;
                        w_sum      = RxData;
                    end else begin
                        w_byte_cnt = 4'd0;
                        w_sum      = 8'd0;
                        w_state    = HUNT0;
                    end
                end else if (r_gap_cnt == (TIMEOUT - 20'd1)) begin
                    w_timeout_err = 1'b1;
                    w_gap_cnt     = 20'd0;
                    w_byte_cnt    = 4'd0;
                    w_sum         = 8'd0;
                    w_state       = HUNT0;
                end else begin
                    w_gap_cnt = r_gap_cnt + 20'd1;
                end
            end

            BODY: begin
                if (RxEn) begin
                    w_gap_cnt  = 20'd0;
                    w_shift    = {r_shift[95:0], RxData};
                    w_byte_cnt = r_byte_cnt + 4'd1;
                    // r_byte_cnt is the index of the byte being stored.
                    if (r_byte_cnt <= 4'd11) begin
                        w_sum = r_sum + RxData;
                    end
                    if (r_byte_cnt == 4'd12) begin
                        w_state = CHECK;
                    end
                end else if (r_gap_cnt == (TIMEOUT - 20'd1)) begin
                    w_timeout_err = 1'b1;
                    w_gap_cnt     = 20'd0;
                    w_byte_cnt    = 4'd0;
                    w_sum         = 8'd0;
                    w_state       = HUNT0;
                end else begin
                    w_gap_cnt = r_gap_cnt + 20'd1;
                end
            end

            default: begin
                w_state = HUNT0;
            end
        endcase
    end

    assign DataEn     = r_data_en;
    assign DataOut    = r_data_out;
    assign ChkErr     = r_chk_err;
    assign TimeoutErr = r_timeout_err;
    assign OvrErr     = r_ovr_err;
    assign FrameCnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rec_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rec_frame_assembler
//  Description : Directed self-checking bench for rec_frame_assembler. One
//                instance (EN_HOLD=16) covers good/bad/timeout/resync/reset,
//                a second instance (EN_HOLD=200) covers overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rec_frame_assembler;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_en, rx_en2;
    logic [7:0]   rx_data, rx_data2;

    logic         data_en, data_en2;
    logic [103:0] data_out, data_out2;
    logic         chk_err, chk_err2;
    logic         to_err, to_err2;
    logic         ovr_err, ovr_err2;
    logic [15:0]  frame_cnt, frame_cnt2;

    int total = 0;
    int bad   = 0;
    int en_hi, n_chk, n_to, n_ovr;
    int en_hi2, n_err2, n_ovr2;

    always #5 clk = ~clk;

    rec_frame_assembler #(
        .HEAD0(8'h55), .HEAD1(8'hAA), .TIMEOUT(20'd1000), .EN_HOLD(8'd16)
    ) u_dut (
        .Clk(clk), .Rst(rst), .RxEn(rx_en), .RxData(rx_data),
        .DataEn(data_en), .DataOut(data_out), .ChkErr(chk_err),
        .TimeoutErr(to_err), .OvrErr(ovr_err), .FrameCnt(frame_cnt)
    );

    rec_frame_assembler #(
        .HEAD0(8'h55), .HEAD1(8'hAA), .TIMEOUT(20'd1000), .EN_HOLD(8'd200)
    ) u_ovr (
        .Clk(clk), .Rst(rst), .RxEn(rx_en2), .RxData(rx_data2),
        .DataEn(data_en2), .DataOut(data_out2), .ChkErr(chk_err2),
        .TimeoutErr(to_err2), .OvrErr(ovr_err2), .FrameCnt(frame_cnt2)
    );

    task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and tally the outputs seen there.
    task automatic step();
        @(negedge clk);
        if (data_en)  en_hi++;
        if (chk_err)  n_chk++;
        if (to_err)   n_to++;
        if (ovr_err)  n_ovr++;
        if (data_en2) en_hi2++;
        if (chk_err2 || to_err2) n_err2++;
        if (ovr_err2) n_ovr2++;
    endtask

    task automatic clear_counts();
        en_hi = 0; n_chk = 0; n_to = 0; n_ovr = 0;
        en_hi2 = 0; n_err2 = 0; n_ovr2 = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_en   = 1'b1;
        rx_data = b;
        step();
        rx_en   = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send2(input logic [7:0] b);
        rx_en2   = 1'b1;
        rx_data2 = b;
        step();
        rx_en2   = 1'b0;
    endtask

    // Sends bytes first..12 of a frame; no idle after the final byte.
    task automatic send_frame(input logic [103:0] f, input int first, input int gap);
        for (int i = first; i < 13; i++) begin
            send(f[103 - 8*i -: 8], (i == 12) ? 0 : gap);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [103:0] good_f, bad_f, frame2;
        int k;
        good_f = 104'h55AA0102030405060708090A36;
        bad_f  = 104'h55AA0102030405060708090A37;
        frame2 = {8'h55, 8'hAA, 80'd0, 8'hFF};

        rst = 1'b1; rx_en = 1'b0; rx_en2 = 1'b0; rx_data = 8'h00; rx_data2 = 8'h00;
        clear_counts();
        repeat (3) step();
        check("rst_dataen",   data_en,   0);
        check("rst_dataout",  data_out,  0);
        check("rst_framecnt", frame_cnt, 0);
        check("rst_errs",     {chk_err, to_err, ovr_err}, 0);
        rst = 1'b0;
        repeat (3) step();

        // Good frame, 100 cycles between bytes
        clear_counts();
        send_frame(good_f, 0, 99);
        check("good_latency_low", data_en, 0);
        step();
        check("good_dataen",   data_en,   1);
        check("good_dataout",  data_out,  good_f);
        check("good_framecnt", frame_cnt, 1);
        repeat (30) step();
        check("good_hold_len",   en_hi, 16);
        check("good_no_errs",    n_chk + n_to + n_ovr, 0);
        check("good_after_hold", data_en, 0);
        check("good_out_stable", data_out, good_f);

        // Bad checksum
        clear_counts();
        send_frame(bad_f, 0, 3);
        step();
        check("chk_pulse", chk_err, 1);
        repeat (20) step();
        check("chk_count",    n_chk, 1);
        check("chk_no_en",    en_hi, 0);
        check("chk_dataout",  data_out, good_f);
        check("chk_framecnt", frame_cnt, 1);

        // Gap timeout after a partial frame
        clear_counts();
        send(8'h55, 3); send(8'hAA, 3); send(8'h01, 3); send(8'h02, 0);
        k = 0;
        while (!to_err && k < 1200) begin
            step();
            k++;
        end
        check("to_fired",  to_err, 1);
        check("to_window", (k >= 999 && k <= 1000), 1);
        repeat (5) step();
        check("to_single", n_to, 1);
        check("to_no_chk", n_chk + n_ovr + en_hi, 0);
        send_frame(good_f, 0, 2);
        step();
        check("to_next_en",  data_en,   1);
        check("to_next_cnt", frame_cnt, 2);
        repeat (20) step();

        // Resync through 00 55 55 AA
        clear_counts();
        send(8'h00, 2); send(8'h55, 2); send(8'h55, 2); send(8'hAA, 2);
        send_frame(good_f, 2, 2);
        step();
        check("resync_en",  data_en,   1);
        check("resync_out", data_out,  good_f);
        check("resync_cnt", frame_cnt, 3);
        repeat (20) step();
        check("resync_no_errs", n_chk + n_to + n_ovr, 0);

        // Overrun on the long-hold instance, bytes on consecutive cycles
        clear_counts();
        for (int i = 0; i < 13; i++) send2(good_f[103 - 8*i -: 8]);
        for (int i = 0; i < 13; i++) send2(frame2[103 - 8*i -: 8]);
        step();
        check("ovr_pulse", ovr_err2, 1);
        repeat (220) step();
        check("ovr_count",    n_ovr2, 1);
        check("ovr_framecnt", frame_cnt2, 1);
        check("ovr_dataout",  data_out2, good_f);
        check("ovr_hold_len", en_hi2, 200);
        check("ovr_no_errs",  n_err2, 0);

        // Reset in the middle of a frame
        for (int i = 0; i < 6; i++) send(good_f[103 - 8*i -: 8], 2);
        rst = 1'b1;
        #1;
        check("mid_rst_dataen",   data_en,   0);
        check("mid_rst_dataout",  data_out,  0);
        check("mid_rst_framecnt", frame_cnt, 0);
        check("mid_rst_cnt2",     frame_cnt2, 0);
        step();
        step();
        rst = 1'b0;
        step();
        clear_counts();
        send_frame(good_f, 0, 2);
        step();
        check("post_rst_en",  data_en,   1);
        check("post_rst_cnt", frame_cnt, 1);
        check("post_rst_out", data_out,  good_f);
        repeat (5) step();
        check("post_rst_no_errs", n_chk + n_to + n_ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
